// File: rtl/pulse_xfer_pkg.sv
// pulse_xfer_pkg: shared types and defaults for the pulse transfer scheduler.
package pulse_xfer_pkg;
    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_HI, WAIT_LO} state_t;
    localparam int NUM_REQ_DEF = 4;
    localparam int CNT_W_DEF = 4;
    localparam int TAG_W = $clog2(NUM_REQ_DEF);
    typedef logic [CNT_W_DEF-1:0] cnt_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting at ptr (inclusive).
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    localparam int TW = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [TW-1:0]      ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [TW-1:0]      idx,
    output logic               vld
);
    logic [TW-1:0] j;
    always_comb begin
        idx = '0;
        vld = 1'b0;
        j = '0;
        gnt = '0;
        // Walk backwards so the candidate closest to ptr is written last and wins.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j = TW'((int'(ptr) + k) % NUM_REQ);
            if (req[j]) begin
                idx = j;
                vld = 1'b1;
            end
        end
        if (vld) gnt[idx] = 1'b1;
    end
endmodule

// File: rtl/pulse_xfer_sched.sv
// pulse_xfer_sched: round-robin scheduler sharing one pulse-sync channel, paced on the returned ack level.
module pulse_xfer_sched
    import pulse_xfer_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int TIMEOUT = 255,
    localparam int TW = $clog2(NUM_REQ),
    localparam int WW = $clog2(TIMEOUT + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req_pulse,
    input  logic               sync_ack,
    input  logic               clr_err,
    output logic               sync_pulse,
    output logic [TW-1:0]      tag,
    output logic               busy,
    output logic [NUM_REQ-1:0] pending_ovf,
    output logic               timeout_err
);
    state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q [NUM_REQ];
    logic [CNT_W-1:0] cnt_d [NUM_REQ];
    logic [TW-1:0] ptr_q, ptr_d, tag_q, tag_d, gidx;
    logic [WW-1:0] wcnt_q, wcnt_d;
    logic [NUM_REQ-1:0] nz, gnt, ovf_ev, ovf_q, ovf_d;
    logic sync_pulse_q, sync_pulse_d, busy_q, busy_d, err_q, err_d, vld, grant, stay;

    always_comb begin
        nz = '0;
        for (int i = 0; i < NUM_REQ; i++) nz[i] = |cnt_q[i];
    end

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req(nz),
        .ptr(ptr_q),
        .gnt(gnt),
        .idx(gidx),
        .vld(vld)
    );

    always_comb begin
        state_d = state_q;
        tag_d = tag_q;
        ptr_d = ptr_q;
        grant = 1'b0;
        case (state_q)
            IDLE: if (vld) begin
                state_d = LAUNCH;
                tag_d = gidx;
                ptr_d = (gidx == TW'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
                grant = 1'b1;
            end
            LAUNCH: state_d = WAIT_HI;
            WAIT_HI: if (sync_ack) state_d = WAIT_LO;
            WAIT_LO: if (!sync_ack) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Counter clears on any exit or state change, so each wait state starts from zero.
        stay = (state_q == WAIT_HI && !sync_ack) || (state_q == WAIT_LO && sync_ack);
        wcnt_d = stay ? ((wcnt_q == WW'(TIMEOUT)) ? wcnt_q : wcnt_q + 1'b1) : '0;
        err_d = (stay && wcnt_q == WW'(TIMEOUT - 1)) || (err_q && !clr_err);
        sync_pulse_d = state_q == LAUNCH;
        busy_d = state_d != IDLE;
        ovf_ev = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cnt_d[i] = (req_pulse[i] && !(grant && gnt[i]) && cnt_q[i] != '1) ? cnt_q[i] + 1'b1 :
                       (!req_pulse[i] && grant && gnt[i]) ? cnt_q[i] - 1'b1 : cnt_q[i];
            ovf_ev[i] = req_pulse[i] && !(grant && gnt[i]) && cnt_q[i] == '1;
        end
        ovf_d = ovf_ev | (ovf_q & ~{NUM_REQ{clr_err}});
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q <= '{default: '0};
            ptr_q <= '0;
            tag_q <= '0;
            wcnt_q <= '0;
            ovf_q <= '0;
            err_q <= 1'b0;
            sync_pulse_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            ptr_q <= ptr_d;
            tag_q <= tag_d;
            wcnt_q <= wcnt_d;
            ovf_q <= ovf_d;
            err_q <= err_d;
            sync_pulse_q <= sync_pulse_d;
            busy_q <= busy_d;
        end
    end

    assign sync_pulse = sync_pulse_q;
    assign tag = tag_q;
    assign busy = busy_q;
    assign pending_ovf = ovf_q;
    assign timeout_err = err_q;
endmodule

// File: tb/tb_pulse_xfer_sched.sv
// tb_pulse_xfer_sched: directed checks of launch timing, round-robin, ack pacing, saturation and timeout.
module tb_pulse_xfer_sched;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [3:0] req_pulse = '0;
    logic sync_ack = 1'b0;
    logic clr_err = 1'b0;
    logic sync_pulse, busy, timeout_err;
    logic [1:0] tag;
    logic [3:0] pending_ovf;
    int n_assert = 0;
    int n_fail = 0;
    int p;

    always #5 clk = ~clk;

    pulse_xfer_sched dut (
        .clk(clk),
        .reset(reset),
        .req_pulse(req_pulse),
        .sync_ack(sync_ack),
        .clr_err(clr_err),
        .sync_pulse(sync_pulse),
        .tag(tag),
        .busy(busy),
        .pending_ovf(pending_ovf),
        .timeout_err(timeout_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_pulse(input int lim);
        int w = 0;
        while (sync_pulse !== 1'b1 && w < lim) begin
            tick();
            w++;
        end
        chk("pulse_seen", {31'd0, sync_pulse}, 1);
    endtask

    task automatic xfer(input int hi, input int lo, input logic [1:0] t);
        int q = 0;
        wait_pulse(20);
        chk("xfer_tag", {30'd0, tag}, {30'd0, t});
        chk("xfer_busy", {31'd0, busy}, 1);
        repeat (hi) begin
            tick();
            q += int'(sync_pulse);
        end
        sync_ack = 1'b1;
        repeat (lo) begin
            tick();
            q += int'(sync_pulse);
        end
        sync_ack = 1'b0;
        tick();
        chk("xfer_single_pulse", q, 0);
    endtask

    task automatic quiet(input string name, input int n);
        int q = 0;
        repeat (n) begin
            tick();
            q += int'(sync_pulse);
        end
        chk(name, q, 0);
    endtask

    initial begin
        tick();
        tick();
        reset = 1'b0;
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_pulse", {31'd0, sync_pulse}, 0);
        chk("rst_tag", {30'd0, tag}, 0);
        chk("rst_ovf", {28'd0, pending_ovf}, 0);
        chk("rst_err", {31'd0, timeout_err}, 0);
        for (int i = 0; i < 4; i++) chk($sformatf("rst_cnt%0d", i), {28'd0, dut.cnt_q[i]}, 0);

        // single request on requester 2
        req_pulse = 4'b0100;
        tick();
        req_pulse = '0;
        chk("t1_cnt_inc", {28'd0, dut.cnt_q[2]}, 1);
        chk("t1_busy_before_grant", {31'd0, busy}, 0);
        tick();
        chk("t1_busy_grant", {31'd0, busy}, 1);
        chk("t1_tag", {30'd0, tag}, 2);
        chk("t1_cnt_dec", {28'd0, dut.cnt_q[2]}, 0);
        chk("t1_no_pulse_yet", {31'd0, sync_pulse}, 0);
        tick();
        chk("t1_pulse", {31'd0, sync_pulse}, 1);
        p = 0;
        repeat (6) begin
            tick();
            p += int'(sync_pulse);
        end
        sync_ack = 1'b1;
        repeat (6) begin
            tick();
            p += int'(sync_pulse);
        end
        chk("t1_busy_round_trip", {31'd0, busy}, 1);
        chk("t1_tag_held", {30'd0, tag}, 2);
        sync_ack = 1'b0;
        tick();
        chk("t1_idle", {31'd0, busy}, 0);
        chk("t1_one_pulse", p, 0);
        quiet("t1_quiet", 4);

        // round-robin order from a fresh pointer
        do_reset();
        req_pulse = 4'b1111;
        tick();
        req_pulse = '0;
        xfer(4, 4, 2'd0);
        xfer(4, 4, 2'd1);
        xfer(4, 4, 2'd2);
        xfer(4, 4, 2'd3);
        tick();
        for (int i = 0; i < 4; i++) chk($sformatf("t2_cnt%0d", i), {28'd0, dut.cnt_q[i]}, 0);
        chk("t2_idle", {31'd0, busy}, 0);

        // ack held high blocks the next launch
        do_reset();
        req_pulse = 4'b0011;
        tick();
        req_pulse = '0;
        wait_pulse(5);
        chk("t3_first_tag", {30'd0, tag}, 0);
        sync_ack = 1'b1;
        p = 0;
        repeat (20) begin
            tick();
            p += int'(sync_pulse);
        end
        chk("t3_no_pulse_ack_high", p, 0);
        chk("t3_busy_wait_lo", {31'd0, busy}, 1);
        sync_ack = 1'b0;
        tick();
        chk("t3_idle_no_pulse", {31'd0, sync_pulse}, 0);
        tick();
        chk("t3_launch_no_pulse", {31'd0, sync_pulse}, 0);
        chk("t3_second_tag", {30'd0, tag}, 1);
        tick();
        chk("t3_second_pulse", {31'd0, sync_pulse}, 1);
        tick();
        sync_ack = 1'b1;
        tick();
        tick();
        sync_ack = 1'b0;
        tick();
        chk("t3_idle", {31'd0, busy}, 0);

        // saturation of requester 3 while the channel is stalled
        do_reset();
        req_pulse = 4'b0001;
        tick();
        req_pulse = '0;
        wait_pulse(5);
        req_pulse = 4'b1000;
        repeat (16) tick();
        req_pulse = '0;
        chk("t4_cnt_sat", {28'd0, dut.cnt_q[3]}, 15);
        chk("t4_ovf", {28'd0, pending_ovf}, 4'b1000);
        sync_ack = 1'b1;
        tick();
        sync_ack = 1'b0;
        tick();
        for (int i = 0; i < 15; i++) xfer(1, 1, 2'd3);
        quiet("t4_exactly_15", 5);
        chk("t4_cnt_drained", {28'd0, dut.cnt_q[3]}, 0);
        chk("t4_ovf_sticky", {28'd0, pending_ovf}, 4'b1000);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("t4_ovf_cleared", {28'd0, pending_ovf}, 0);

        // increment and grant on the same edge
        do_reset();
        req_pulse = 4'b0001;
        tick();
        tick();
        req_pulse = '0;
        chk("t5_cnt_kept", {28'd0, dut.cnt_q[0]}, 1);
        chk("t5_busy", {31'd0, busy}, 1);
        xfer(2, 2, 2'd0);
        xfer(2, 2, 2'd0);
        quiet("t5_quiet", 4);
        chk("t5_cnt_zero", {28'd0, dut.cnt_q[0]}, 0);

        // timeout in WAIT_HI, then reset mid-operation
        do_reset();
        req_pulse = 4'b0010;
        tick();
        req_pulse = '0;
        wait_pulse(5);
        req_pulse = 4'b0100;
        tick();
        req_pulse = '0;
        repeat (253) tick();
        chk("t6_err_not_yet", {31'd0, timeout_err}, 0);
        tick();
        chk("t6_err_set", {31'd0, timeout_err}, 1);
        chk("t6_still_busy", {31'd0, busy}, 1);
        chk("t6_tag_valid", {30'd0, tag}, 1);
        chk("t6_pending", {28'd0, dut.cnt_q[2]}, 1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("t6_err_cleared", {31'd0, timeout_err}, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_rst_busy", {31'd0, busy}, 0);
        chk("t6_rst_tag", {30'd0, tag}, 0);
        chk("t6_rst_cnt", {28'd0, dut.cnt_q[2]}, 0);
        chk("t6_rst_err", {31'd0, timeout_err}, 0);
        chk("t6_rst_ovf", {28'd0, pending_ovf}, 0);
        quiet("t6_discarded", 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
